// File: rtl/traffic_request_latch.sv
// traffic_request_latch
//   Conditions the raw NS/EW loop-detector inputs into clean, latched vehicle
//   requests for the traffic light controller. Each direction runs a 2-FF
//   synchroniser, a counter debounce and a request latch. A request is set on
//   a debounced arrival and held until that direction sees a green on its
//   straight or right lamp.
//
//   Optional feature macro: SENSOR_FAULT_EN
//     When defined, a 1 s tick is derived from CLK_FREQ. A direction whose
//     presence persists for STUCK_SEC seconds raises a sticky fault bit, and
//     that fault forces the direction's request high so the controller keeps
//     cycling. When undefined, fault is tied to 2'b00 and no timers exist.
//
// Ports
//   clk                 system clock
//   rst                 synchronous, active-high reset
//   ns_raw, ew_raw      asynchronous loop-detector inputs, active-high
//   NS_str, NS_right    NS lamps, {R,Y,G} one-hot (green = 3'b001)
//   EW_str, EW_right    EW lamps
//   ns_req, ew_req      latched requests to the controller
//   ns_present          debounced NS presence level
//   ew_present          debounced EW presence level
//   fault               {ew_fault, ns_fault} stuck-sensor flags

// Per-direction lane: synchroniser, debounce, request latch (and fault timer).
module traffic_request_lane #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int STUCK_SEC  = 300
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic serve,
`ifdef SENSOR_FAULT_EN
  input  logic tick,
`endif
  output logic present,
  output logic req,
  output logic fault
);

  if (DEB_CYCLES < 2 || STUCK_SEC < 1) begin : g_bad_cfg
    $error("traffic_request_lane: DEB_CYCLES must be >= 2 and STUCK_SEC >= 1");
  end

  localparam int DW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic          sync1, sync2;
  logic          present_d;
  logic          req_q;
  logic [DW-1:0] deb_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      present   <= 1'b0;
      present_d <= 1'b0;
      req_q     <= 1'b0;
      deb_cnt   <= '0;
    end else begin
      sync1     <= raw;
      sync2     <= sync1;
      present_d <= present;
      // Counter only runs while the synced level disagrees with the debounced
      // level; any agreement restarts the qualification window.
      if (sync2 == present) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        present <= sync2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
      // A fresh arrival beats a simultaneous green so it is not lost.
      if (present && !present_d)
        req_q <= 1'b1;
      else if (serve)
        req_q <= 1'b0;
    end
  end

`ifdef SENSOR_FAULT_EN
  localparam int SW = $clog2(STUCK_SEC + 1);

  logic [SW-1:0] sec_cnt;
  logic          fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      // Seconds counter saturates at STUCK_SEC; the fault bit is sticky.
      if (!present)
        sec_cnt <= '0;
      else if (tick && sec_cnt != SW'(STUCK_SEC))
        sec_cnt <= sec_cnt + 1'b1;
      if (present && tick && sec_cnt == SW'(STUCK_SEC - 1))
        fault_q <= 1'b1;
    end
  end

  assign fault = fault_q;
  assign req   = req_q | fault_q;
`else
  assign fault = 1'b0;
  assign req   = req_q;
`endif

endmodule

module traffic_request_latch #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int STUCK_SEC  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ns_raw,
  input  logic       ew_raw,
  input  logic [2:0] NS_str,
  input  logic [2:0] NS_right,
  input  logic [2:0] EW_str,
  input  logic [2:0] EW_right,
  output logic       ns_req,
  output logic       ew_req,
  output logic       ns_present,
  output logic       ew_present,
  output logic [1:0] fault
);

  if (CLK_FREQ < 1) begin : g_bad_clk
    $error("traffic_request_latch: CLK_FREQ must be >= 1");
  end

  localparam int         NUM_DIRS = 2;   // index 0 = NS, 1 = EW
  localparam logic [2:0] GREEN    = 3'b001;

  logic [NUM_DIRS-1:0] raw_v, serve_v, present_v, req_v, fault_v;

  assign raw_v   = {ew_raw, ns_raw};
  // Only an exact green code counts as service; invalid codes do not.
  assign serve_v = {(EW_str == GREEN) || (EW_right == GREEN),
                    (NS_str == GREEN) || (NS_right == GREEN)};

`ifdef SENSOR_FAULT_EN
  localparam int TW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick = (tick_cnt == TW'(CLK_FREQ - 1));

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end
`endif

  for (genvar i = 0; i < NUM_DIRS; i++) begin : g_dir
    traffic_request_lane #(
      .DEB_CYCLES (DEB_CYCLES),
      .STUCK_SEC  (STUCK_SEC)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .raw     (raw_v[i]),
      .serve   (serve_v[i]),
`ifdef SENSOR_FAULT_EN
      .tick    (tick),
`endif
      .present (present_v[i]),
      .req     (req_v[i]),
      .fault   (fault_v[i])
    );
  end

  assign {ew_req, ns_req}         = req_v;
  assign {ew_present, ns_present} = present_v;
  assign fault                    = fault_v;

endmodule
